router_endpoint: RTL

ROUTER_ENDPOINT -- requirements
Module: router_endpoint

---
 rtl/router_pkg.sv | 14 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/router_endpoint.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and FSM state type for the router endpoint
package router_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, registered head, push allowed when full if popping
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is taken then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; a word becomes visible at the head only from the next cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/router_endpoint.sv
// rtl/router_endpoint.sv - router port endpoint: TX burst sender and RX receive buffer
module router_endpoint
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] link_data_o,
  output logic                  link_enable_o,
  input  logic [DATA_WIDTH-1:0] link_data_i,
  input  logic                  link_enable_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_overflow_o,
  output logic [LEN_WIDTH-1:0]  rx_count_o
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
  logic                  link_enable_q;
  logic [LEN_WIDTH-1:0]  rx_count_q, rx_count_d;
  logic                  rx_overflow_q, rx_overflow_d;

  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic                  start_accept;

  // TX never takes a word while full, even when the same cycle pops one.
  assign tx_ready_o = ~tx_full;
  assign tx_push    = tx_valid_i & tx_ready_o;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .data_i  (tx_data_i),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // RX accepts when there is room, including room freed by a same-cycle pop.
  assign rx_valid_o = ~rx_empty;
  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign rx_push    = link_enable_i & (~rx_full | rx_pop);
  assign rx_drop    = link_enable_i & ~rx_push;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .data_i  (link_data_i),
    .pop_i   (rx_pop),
    .data_o  (rx_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign start_accept = cfg_start & (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_SEND) || (state_q == ST_DONE);

  // Burst FSM: pops one TX word per non-empty SEND cycle until the length is used up.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tx_pop      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            state_d     = ST_SEND;
            remaining_d = cfg_len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and remaining-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Link output data is forced to zero on idle cycles.
  assign link_data_d = tx_pop ? tx_head : '0;

  // Registered link output: a word popped this cycle is driven next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_data_q   <= '0;
      link_enable_q <= 1'b0;
    end else begin
      link_data_q   <= link_data_d;
      link_enable_q <= tx_pop;
    end
  end

  assign link_data_o   = link_data_q;
  assign link_enable_o = link_enable_q;

  // RX statistics; an accepted start clears them and overrides a colliding push or drop.
  always_comb begin
    rx_count_d    = rx_count_q;
    rx_overflow_d = rx_overflow_q;
    if (start_accept) begin
      rx_count_d    = '0;
      rx_overflow_d = 1'b0;
    end else begin
      if (rx_push) rx_count_d = rx_count_q + LEN_WIDTH'(1);
      if (rx_drop) rx_overflow_d = 1'b1;
    end
  end

  // RX statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_count_q    <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      rx_count_q    <= rx_count_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  assign rx_count_o    = rx_count_q;
  assign rx_overflow_o = rx_overflow_q;

endmodule
